// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: datapath widths, the canonical NOP encoding
// and the fetch FSM state encodings.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs; flush clears
// pointers and count in one edge and wins over any coincident push or pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: one-outstanding instruction memory reads, buffered {pc, instr}
// presented to decode, with redirect flush and stale-response dropping.
//
// state      | meaning
// FETCH_REQ  | idle; may issue a read when the buffer has room
// FETCH_WAIT | one read outstanding; its data will be buffered
// FETCH_DROP | one read outstanding after a redirect; its data is discarded
module instr_fetch_buffer
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_advance_o,
    input  logic            redirect_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [XLEN-1:0] pc_word;
    logic            req, adv, push, pop;
    logic [CNT_W-1:0] fifo_count;
    logic            fifo_full, fifo_empty;
    logic [XLEN+31:0] fifo_rdata;

    assign pc_word = pc_i & ~XLEN'(3);

    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        req       = 1'b0;
        adv       = 1'b0;
        push      = 1'b0;
        unique case (state_q)
            FETCH_REQ: begin
                req = (fifo_count < CNT_W'(DEPTH)) && !redirect_i;
                if (req && imem_gnt_i) begin
                    adv       = 1'b1;
                    pend_pc_d = pc_word;
                    state_d   = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid_i) begin
                    push    = !redirect_i;
                    state_d = FETCH_REQ;
                end else if (redirect_i) begin
                    state_d = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (imem_rvalid_i) begin
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH_REQ;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign imem_req_o    = req && reset;
    assign pc_advance_o  = adv && reset;
    assign imem_addr_o   = reset ? pc_word : '0;
    assign instr_valid_o = !fifo_empty;
    assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
    assign instr_pc_o    = fifo_rdata[XLEN+31:32];
    assign instr_o       = fifo_rdata[31:0];

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + 32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (redirect_i),
        .push_i  (push),
        .wdata_i ({pend_pc_q, imem_rdata_i}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
        !(push && fifo_full));
    c_gnt_no_req: cover property (@(posedge clk) disable iff (!reset)
        imem_gnt_i && !imem_req_o);
    c_rvalid_in_req: cover property (@(posedge clk) disable iff (!reset)
        (state_q == FETCH_REQ) && imem_rvalid_i);

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: reset, streaming, backpressure,
// redirects and grant stalls with hand-computed expectations.
module tb_instr_fetch_buffer;

    logic        clk;
    logic        reset;
    logic [31:0] pc_i;
    logic        pc_advance_o;
    logic        redirect_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .pc_i          (pc_i),
        .pc_advance_o  (pc_advance_o),
        .redirect_i    (redirect_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] flags;
        reset = 1'b0; pc_i = '0; redirect_i = 0; imem_gnt_i = 0;
        imem_rvalid_i = 0; imem_rdata_i = '0; instr_ready_i = 0;
        #12;
        flags = {imem_req_o, pc_advance_o, instr_valid_o};
        n_tests++;
        if (flags !== 3'b000 || imem_addr_o !== 32'h0 || instr_o !== 32'h0 || instr_pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_init: req/adv/valid=%b addr=%h instr=%h pc=%h, expected all 0", flags, imem_addr_o, instr_o, instr_pc_o);
        end
        tick(); reset = 1'b1; pc_i = 32'h40; imem_gnt_i = 1; #1;
        n_tests++;
        if ({imem_req_o, pc_advance_o} !== 2'b11 || imem_addr_o !== 32'h40) begin
            n_fail++;
            $display("FAIL reset_first_req: req/adv=%b addr=%h, expected 11 addr 00000040", {imem_req_o, pc_advance_o}, imem_addr_o);
        end
        tick(); imem_gnt_i = 0; #1;
        n_tests++;
        if ({imem_req_o, pc_advance_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_wait_idle: req/adv=%b, expected 00", {imem_req_o, pc_advance_o});
        end
        imem_rvalid_i = 1; imem_rdata_i = 32'hBAD0_BAD0; reset = 1'b0; #1;
        flags = {imem_req_o, pc_advance_o, instr_valid_o};
        n_tests++;
        if (flags !== 3'b000 || imem_addr_o !== 32'h0 || instr_o !== 32'h0 || instr_pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: req/adv/valid=%b addr=%h instr=%h pc=%h, expected all 0", flags, imem_addr_o, instr_o, instr_pc_o);
        end
        tick(); tick(); reset = 1'b1; #1;
        n_tests++;
        if ({imem_req_o, pc_advance_o, instr_valid_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release: req/adv/valid=%b, expected 100", {imem_req_o, pc_advance_o, instr_valid_o});
        end
        tick(); imem_rvalid_i = 0; #1;
        tick();
        n_tests++;
        if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_late_rvalid: valid=%b req=%b, expected valid 0 req 1", instr_valid_o, imem_req_o);
        end
    endtask

    task automatic test_stream();
        int adv_n = 0;
        instr_ready_i = 1;
        tick(); pc_i = 32'h0; imem_gnt_i = 1; #1;
        adv_n += int'(pc_advance_o);
        n_tests++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL stream_req0: req=%b addr=%h, expected 1 00000000", imem_req_o, imem_addr_o);
        end
        tick(); imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'h0000_0013; #1;
        adv_n += int'(pc_advance_o);
        n_tests++;
        if (imem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_no_req_outstanding: req=%b, expected 0", imem_req_o);
        end
        tick(); imem_rvalid_i = 0; pc_i = 32'h4; imem_gnt_i = 1; #1;
        adv_n += int'(pc_advance_o);
        n_tests++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0 || instr_o !== 32'h0000_0013 || imem_addr_o !== 32'h4) begin
            n_fail++;
            $display("FAIL stream_head0: valid=%b pc=%h instr=%h addr=%h, expected 1 0 00000013 4", instr_valid_o, instr_pc_o, instr_o, imem_addr_o);
        end
        tick(); imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'h0010_0093; #1;
        adv_n += int'(pc_advance_o);
        n_tests++;
        if (instr_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_popped0: valid=%b, expected 0", instr_valid_o);
        end
        tick(); imem_rvalid_i = 0; pc_i = 32'h8; imem_gnt_i = 1; #1;
        adv_n += int'(pc_advance_o);
        n_tests++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h4 || instr_o !== 32'h0010_0093) begin
            n_fail++;
            $display("FAIL stream_head1: valid=%b pc=%h instr=%h, expected 1 4 00100093", instr_valid_o, instr_pc_o, instr_o);
        end
        tick(); imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'h0020_0113; #1;
        adv_n += int'(pc_advance_o);
        tick(); imem_rvalid_i = 0; #1;
        adv_n += int'(pc_advance_o);
        n_tests++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h8 || instr_o !== 32'h0020_0113) begin
            n_fail++;
            $display("FAIL stream_head2: valid=%b pc=%h instr=%h, expected 1 8 00200113", instr_valid_o, instr_pc_o, instr_o);
        end
        tick();
        n_tests++;
        if (instr_valid_o !== 1'b0 || adv_n != 3) begin
            n_fail++;
            $display("FAIL stream_end: valid=%b advance_pulses=%0d, expected 0 and 3", instr_valid_o, adv_n);
        end
    endtask

    task automatic test_backpressure();
        instr_ready_i = 0;
        tick(); pc_i = 32'h100; imem_gnt_i = 1; #1;
        tick(); imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'h11; #1;
        tick(); imem_rvalid_i = 0; pc_i = 32'h104; imem_gnt_i = 1; #1;
        n_tests++;
        if ({imem_req_o, pc_advance_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL bp_second_req: req/adv=%b, expected 11", {imem_req_o, pc_advance_o});
        end
        tick(); imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'h22; #1;
        tick(); imem_rvalid_i = 0; pc_i = 32'h108; imem_gnt_i = 1; #1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({imem_req_o, pc_advance_o} !== 2'b00 || instr_valid_o !== 1'b1 || instr_pc_o !== 32'h100) begin
                n_fail++;
                $display("FAIL bp_full_hold[%0d]: req/adv=%b valid=%b pc=%h, expected 00 1 100", i, {imem_req_o, pc_advance_o}, instr_valid_o, instr_pc_o);
            end
            tick();
        end
        instr_ready_i = 1; #1;
        tick(); instr_ready_i = 0; #1;
        n_tests++;
        if ({imem_req_o, pc_advance_o} !== 2'b11 || imem_addr_o !== 32'h108 || instr_pc_o !== 32'h104) begin
            n_fail++;
            $display("FAIL bp_one_slot: req/adv=%b addr=%h head=%h, expected 11 108 104", {imem_req_o, pc_advance_o}, imem_addr_o, instr_pc_o);
        end
        tick(); imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'h33; #1;
        tick(); imem_rvalid_i = 0; imem_gnt_i = 1; #1;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({imem_req_o, pc_advance_o} !== 2'b00) begin
                n_fail++;
                $display("FAIL bp_refull[%0d]: req/adv=%b, expected 00", i, {imem_req_o, pc_advance_o});
            end
            tick();
        end
        imem_gnt_i = 0; redirect_i = 1; #1;
        tick(); redirect_i = 0; #1;
        n_tests++;
        if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_flush: valid=%b req=%b, expected 0 1", instr_valid_o, imem_req_o);
        end
    endtask

    task automatic test_redirect_wait();
        instr_ready_i = 1;
        tick(); pc_i = 32'h10; imem_gnt_i = 1; #1;
        n_tests++;
        if ({imem_req_o, pc_advance_o} !== 2'b11 || imem_addr_o !== 32'h10) begin
            n_fail++;
            $display("FAIL rw_req: req/adv=%b addr=%h, expected 11 10", {imem_req_o, pc_advance_o}, imem_addr_o);
        end
        tick(); imem_gnt_i = 0; redirect_i = 1; pc_i = 32'h80; #1;
        n_tests++;
        if ({imem_req_o, pc_advance_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL rw_redirect_cycle: req/adv=%b, expected 00", {imem_req_o, pc_advance_o});
        end
        tick(); redirect_i = 0; #1;
        n_tests++;
        if (imem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_drop_no_req: req=%b, expected 0", imem_req_o);
        end
        tick(); imem_rvalid_i = 1; imem_rdata_i = 32'h0000_DEAD; #1;
        tick(); imem_rvalid_i = 0; #1;
        n_tests++;
        if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h80) begin
            n_fail++;
            $display("FAIL rw_dropped: valid=%b req=%b addr=%h, expected 0 1 80", instr_valid_o, imem_req_o, imem_addr_o);
        end
        imem_gnt_i = 1;
        tick(); imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'h0050_0293; #1;
        tick(); imem_rvalid_i = 0; #1;
        n_tests++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h80 || instr_o !== 32'h0050_0293) begin
            n_fail++;
            $display("FAIL rw_refetch: valid=%b pc=%h instr=%h, expected 1 80 00500293", instr_valid_o, instr_pc_o, instr_o);
        end
        tick();
    endtask

    task automatic test_redirect_rvalid();
        instr_ready_i = 0;
        tick(); pc_i = 32'h200; imem_gnt_i = 1; #1;
        tick(); imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'hAAAA_0001; #1;
        tick(); imem_rvalid_i = 0; pc_i = 32'h204; imem_gnt_i = 1; #1;
        tick(); imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'hBBBB_0002; redirect_i = 1; #1;
        n_tests++;
        if (instr_valid_o !== 1'b1 || pc_advance_o !== 1'b0 || instr_pc_o !== 32'h200) begin
            n_fail++;
            $display("FAIL rr_before_flush: valid=%b adv=%b pc=%h, expected 1 0 200", instr_valid_o, pc_advance_o, instr_pc_o);
        end
        tick(); imem_rvalid_i = 0; redirect_i = 0; #1;
        n_tests++;
        if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_flushed: valid=%b req=%b, expected 0 1", instr_valid_o, imem_req_o);
        end
        tick();
        n_tests++;
        if (instr_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_nothing_pushed: valid=%b, expected 0", instr_valid_o);
        end
    endtask

    task automatic test_gnt_stall();
        int adv_n = 0;
        instr_ready_i = 0;
        tick(); pc_i = 32'h300; imem_gnt_i = 1; #1;
        tick(); imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'hE000_0000; #1;
        tick(); imem_rvalid_i = 0; pc_i = 32'h306; #1;
        for (int i = 0; i < 3; i++) begin
            adv_n += int'(pc_advance_o);
            n_tests++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h304) begin
                n_fail++;
                $display("FAIL gs_stall[%0d]: req=%b addr=%h, expected 1 304", i, imem_req_o, imem_addr_o);
            end
            tick();
        end
        imem_gnt_i = 1; #1;
        adv_n += int'(pc_advance_o);
        n_tests++;
        if (adv_n != 1 || pc_advance_o !== 1'b1) begin
            n_fail++;
            $display("FAIL gs_advance: pulses=%0d adv=%b, expected 1 pulse on gnt cycle", adv_n, pc_advance_o);
        end
        tick(); imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'hE000_0001; instr_ready_i = 1; #1;
        n_tests++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h300) begin
            n_fail++;
            $display("FAIL gs_head_before: valid=%b pc=%h, expected 1 300", instr_valid_o, instr_pc_o);
        end
        tick(); imem_rvalid_i = 0; instr_ready_i = 0; #1;
        n_tests++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h304 || instr_o !== 32'hE000_0001) begin
            n_fail++;
            $display("FAIL gs_push_pop: valid=%b pc=%h instr=%h, expected 1 304 e0000001", instr_valid_o, instr_pc_o, instr_o);
        end
        instr_ready_i = 1;
        tick(); instr_ready_i = 0; #1;
        n_tests++;
        if (instr_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL gs_count_one: valid=%b after single pop, expected 0", instr_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid();
        test_gnt_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
